hazard_detect_unit: RTL and testbench

Consumer of the ID stage's hazard-side interface. Each cycle it takes the decoded source registers, two-source flag, destination and control bits of the instruction in ID, and tracks in-flight register writers in a two-entry scoreboard (EXE and MEM slots). It drives `hazard` back to ID, which freezes PC/IF/ID and injects a bubble. It supports forwarding-on and forwarding-off modes, and a status-register hazard for conditional instructions.

---
 rtl/hazard_detect_unit.sv | 110 +++++++++++
 tb/tb_hazard_detect_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard detector: a two-slot (EXE/MEM) writer scoreboard that raises a
// combinational stall request for register (RAW) and status-register hazards.
module hazard_detect_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ID_valid,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             Two_src,
    input  logic             ID_WB_EN,
    input  logic             ID_MEM_R_EN,
    input  logic             ID_S,
    input  logic [3:0]       ID_Dest,
    input  logic             ID_cond_AL,
    input  logic             Forward_EN,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_r_en;
        logic       s;
        logic [3:0] dest;
    } slot_t;

    slot_t            r_exe;
    slot_t            r_mem;
    logic [CNT_W-1:0] r_stall_count;

    logic  w_hz_exe;
    logic  w_hz_mem;
    logic  w_hazard;
    slot_t w_id_slot;

    // One rule for both stages: only the EXE slot can cause load-use or SR stalls,
    // because forwarding covers everything else and the SR is written at the end of EXE.
    function automatic logic f_slot_hazard(
        input slot_t      slot,
        input logic       is_exe,
        input logic [3:0] rs1,
        input logic [3:0] rs2,
        input logic       two,
        input logic       fwd,
        input logic       cond_al
    );
        logic match;
        logic reg_hz;
        logic sr_hz;
        match  = slot.valid & slot.wb_en & ((slot.dest == rs1) | (two & (slot.dest == rs2)));
        reg_hz = fwd ? (is_exe & match & slot.mem_r_en) : match;
        sr_hz  = is_exe & ~cond_al & slot.valid & slot.s;
        return reg_hz | sr_hz;
    endfunction

    // Hazard decision and the slot image the ID instruction would take into EXE.
    always_comb begin
        w_hz_exe  = 1'b0;
        w_hz_mem  = 1'b0;
        w_hazard  = 1'b0;
        w_id_slot = '0;
        w_hz_exe  = f_slot_hazard(r_exe, 1'b1, src1, src2, Two_src, Forward_EN, ID_cond_AL);
        w_hz_mem  = f_slot_hazard(r_mem, 1'b0, src1, src2, Two_src, Forward_EN, ID_cond_AL);
        if (ID_valid && !flush) begin
            w_hazard = w_hz_exe | w_hz_mem;
        end else begin
            w_hazard = 1'b0;
        end
        // A stalled or flushed instruction must enter EXE as a bubble.
        w_id_slot.valid    = ID_valid & ~w_hazard & ~flush;
        w_id_slot.wb_en    = ID_WB_EN;
        w_id_slot.mem_r_en = ID_MEM_R_EN;
        w_id_slot.s        = ID_S;
        w_id_slot.dest     = ID_Dest;
    end

    // Scoreboard advance: EXE -> MEM -> dropped, frozen while memory is busy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_exe <= '0;
            r_mem <= '0;
        end else if (!mem_stall) begin
            r_mem <= r_exe;
            r_exe <= w_id_slot;
        end else begin
            r_mem <= r_mem;
            r_exe <= r_exe;
        end
    end

    // Saturating count of cycles this unit actually cost the pipeline.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_count <= '0;
        end else if (w_hazard && !mem_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign hazard      = w_hazard;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Scenario-driven bench for hazard_detect_unit; expectations are queued per cycle
// and compared against the DUT at the falling edge.
module tb_hazard_detect_unit;
    localparam int         CNT_W   = 4;
    localparam logic [3:0] CNT_MAX = 4'hF;

    logic             CLK = 1'b0;
    logic             RST;
    logic             ID_valid;
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             Two_src;
    logic             ID_WB_EN;
    logic             ID_MEM_R_EN;
    logic             ID_S;
    logic [3:0]       ID_Dest;
    logic             ID_cond_AL;
    logic             Forward_EN;
    logic             flush;
    logic             mem_stall;
    logic             hazard;
    logic [CNT_W-1:0] stall_count;

    typedef struct {
        string      name;
        logic       h;
        logic [3:0] c;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] exp_cnt = 4'd0;

    hazard_detect_unit #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ID_valid(ID_valid), .src1(src1), .src2(src2),
        .Two_src(Two_src), .ID_WB_EN(ID_WB_EN), .ID_MEM_R_EN(ID_MEM_R_EN),
        .ID_S(ID_S), .ID_Dest(ID_Dest), .ID_cond_AL(ID_cond_AL),
        .Forward_EN(Forward_EN), .flush(flush), .mem_stall(mem_stall),
        .hazard(hazard), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic two, input logic wb, input logic mr, input logic s,
                          input logic [3:0] d, input logic al);
        ID_valid = v; src1 = s1; src2 = s2; Two_src = two; ID_WB_EN = wb;
        ID_MEM_R_EN = mr; ID_S = s; ID_Dest = d; ID_cond_AL = al;
    endtask

    task automatic bubble();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    endtask

    // One cycle: queue expectation, compare at negedge, advance the count model at posedge.
    task automatic step(input string name, input logic exp_h);
        exp_t e;
        e.name = name; e.h = exp_h; e.c = exp_cnt;
        sb.push_back(e);
        @(negedge CLK);
        e = sb.pop_front();
        tests++;
        if (hazard !== e.h) begin
            fails++;
            $display("FAIL %s hazard: got %0b expected %0b", e.name, hazard, e.h);
        end
        tests++;
        if (stall_count !== e.c) begin
            fails++;
            $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.c);
        end
        @(posedge CLK);
        if (RST) exp_cnt = 4'd0;
        else if (e.h && !mem_stall && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 4'd1;
        #1;
    endtask

    task automatic drain();
        bubble();
        step("drain0", 1'b0);
        step("drain1", 1'b0);
    endtask

    task automatic test_reset();
        bubble();
        step("reset_idle", 1'b0);
        set_id(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step("reset_no_writer", 1'b0);
        drain();
    endtask

    task automatic test_fwd_off();
        Forward_EN = 1'b0;
        set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
        step("off_producer", 1'b0);
        set_id(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1);
        step("off_stall1", 1'b1);
        step("off_stall2", 1'b1);
        step("off_issue", 1'b0);
        set_id(1'b1, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step("off_sub_in_exe", 1'b1);
        drain();
    endtask

    task automatic test_fwd_on();
        Forward_EN = 1'b1;
        set_id(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1);
        step("ld_producer", 1'b0);
        set_id(1'b1, 4'd1, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
        step("ld_use_stall", 1'b1);
        step("ld_use_release", 1'b0);
        set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
        step("alu_producer", 1'b0);
        set_id(1'b1, 4'd1, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
        step("alu_use", 1'b0);
        drain();
    endtask

    task automatic test_two_src();
        Forward_EN = 1'b0;
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1);
        step("two_prod_a", 1'b0);
        set_id(1'b1, 4'd3, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1);
        step("two_src_off", 1'b0);
        drain();
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1);
        step("two_prod_b", 1'b0);
        set_id(1'b1, 4'd3, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1);
        step("two_src_on", 1'b1);
        drain();
    endtask

    task automatic test_sr();
        Forward_EN = 1'b1;
        set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1);
        step("sr_adds_a", 1'b0);
        set_id(1'b1, 4'd6, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0);
        step("sr_stall", 1'b1);
        step("sr_release", 1'b0);
        drain();
        set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1);
        step("sr_adds_b", 1'b0);
        set_id(1'b1, 4'd6, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1);
        step("sr_cond_al", 1'b0);
        drain();
    endtask

    task automatic test_mem_stall_flush();
        Forward_EN = 1'b1;
        set_id(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1);
        step("ms_load", 1'b0);
        set_id(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) step("ms_hold", 1'b1);
        mem_stall = 1'b0;
        step("ms_release", 1'b1);
        step("ms_after", 1'b0);
        drain();
        set_id(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1);
        step("fl_load", 1'b0);
        set_id(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1);
        flush = 1'b1;
        step("fl_dominates", 1'b0);
        flush = 1'b0;
        Forward_EN = 1'b0;
        set_id(1'b1, 4'd8, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step("fl_exe_bubble", 1'b0);
        drain();
    endtask

    task automatic test_saturation();
        Forward_EN = 1'b0;
        set_id(1'b1, 4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1);
        for (int i = 0; i < 30; i++) step("sat_chain", (i % 3) != 0);
        step("sat_enter", 1'b0);
        RST = 1'b1;
        step("rst_mid_stall", 1'b1);
        RST = 1'b0;
        step("rst_cleared", 1'b0);
        step("rst_reenter", 1'b1);
        drain();
    endtask

    initial begin
        RST = 1'b1; Forward_EN = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        bubble();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        test_reset();
        test_fwd_off();
        test_fwd_on();
        test_two_src();
        test_sr();
        test_mem_stall_flush();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
